// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-game stimulus block.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        LIT   = 2'd2,
        COOL  = 2'd3
    } state_t;

    localparam int LFSR_W = 8;

    // x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register: feedback taps q[7], q[5], q[4], q[3]
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

    // Bits needed to hold any value 0..max_val (at least one bit)
    function automatic int width_for(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/reaction_stimulus_lfsr.sv
// Free-running 8-bit Fibonacci LFSR that supplies the random part of the pre-LED delay.
module stim_lfsr
    import reaction_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    logic feedback;

    assign feedback = ^(q & LFSR_TAPS);

    // Shift left, inserting the XOR of the tap bits at the bottom
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[LFSR_W-2:0], feedback};
        end
    end

endmodule

// File: rtl/reaction_stimulus.sv
// Reaction-game stimulus: random delay, LED window, cooldown, and hit/timeout/false-start reporting.
module reaction_stimulus
    import reaction_pkg::*;
#(
    parameter int              TICK_DIV  = 1000,
    parameter int              MIN_DELAY = 16,
    parameter int              RAND_BITS = 6,
    parameter int              WINDOW    = 255,
    parameter int              COOLDOWN  = 8,
    parameter logic [7:0]      LFSR_SEED = 8'hA5,
    localparam int             DLY_W     = width_for(MIN_DELAY + 2**RAND_BITS - 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             button,
    output logic             led_on,
    output logic             busy,
    output logic             hit,
    output logic             timeout,
    output logic             false_start,
    output logic [DLY_W-1:0] last_delay
);

    localparam int PRE_W  = width_for(TICK_DIV - 1);
    localparam int WIN_W  = width_for(WINDOW);
    localparam int COOL_W = width_for(COOLDOWN);
    localparam int MAX_AB = (DLY_W > WIN_W) ? DLY_W : WIN_W;
    localparam int CNT_W  = (MAX_AB > COOL_W) ? MAX_AB : COOL_W;

    state_t               state;
    state_t               state_next;
    logic [PRE_W-1:0]     pre_cnt;
    logic                 tick;
    logic [CNT_W-1:0]     tick_cnt;
    logic [CNT_W-1:0]     tick_cnt_inc;
    logic [CNT_W-1:0]     target;
    logic                 span_done;
    logic                 button_prev;
    logic                 press;
    logic [LFSR_W-1:0]    lfsr_q;
    logic [DLY_W-1:0]     delay_load;
    logic                 load;
    logic                 hit_set;
    logic                 timeout_set;
    logic                 fs_set;
    logic                 unused_lfsr_bits;

    stim_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .q     (lfsr_q)
    );

    // Only the low RAND_BITS of the LFSR feed the delay; the rest just keep the sequence long
    assign unused_lfsr_bits = &{1'b0, lfsr_q};

    assign delay_load   = DLY_W'(MIN_DELAY) + DLY_W'(lfsr_q[RAND_BITS-1:0]);
    assign tick         = (pre_cnt == PRE_W'(TICK_DIV - 1));
    assign tick_cnt_inc = tick_cnt + CNT_W'(1);
    assign span_done    = tick && (tick_cnt_inc == target);
    assign press        = button & ~button_prev;

    // Number of ticks the current state lasts before its timed exit
    always_comb begin
        target = '0;
        case (state)
            ARMED:   target = CNT_W'(last_delay);
            LIT:     target = CNT_W'(WINDOW);
            COOL:    target = CNT_W'(COOLDOWN);
            default: target = '0;
        endcase
    end

    // State register; reset drops out of LIT immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a press always beats a tick expiring on the same cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = ARMED;
            ARMED: begin
                if (press)          state_next = COOL;
                else if (span_done) state_next = LIT;
            end
            LIT:   if (press || span_done) state_next = COOL;
            COOL:  if (span_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode and the one-cycle event conditions
    always_comb begin
        busy        = (state != IDLE);
        load        = (state == IDLE) && start;
        hit_set     = (state == LIT) && press;
        timeout_set = (state == LIT) && !press && span_done;
        fs_set      = (state == ARMED) && press;
    end

    // Prescaler and tick counter restart on every transition so durations are whole ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else if (state_next != state) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick && state != IDLE) begin
                tick_cnt <= tick_cnt_inc;
            end
        end
    end

    // Registered outputs and button history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            button_prev <= 1'b0;
            led_on      <= 1'b0;
            hit         <= 1'b0;
            timeout     <= 1'b0;
            false_start <= 1'b0;
            last_delay  <= '0;
        end else begin
            button_prev <= button;
            led_on      <= (state_next == LIT);
            hit         <= hit_set;
            timeout     <= timeout_set;
            if (load) begin
                false_start <= 1'b0;
                last_delay  <= delay_load;
            end else if (fs_set) begin
                false_start <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reaction_stimulus.sv
// Self-checking bench for reaction_stimulus with an outcome-level round model.
module tb_reaction_stimulus;

    localparam int         TD    = 4;
    localparam int         MIN   = 3;
    localparam int         RB    = 2;
    localparam int         WIN   = 5;
    localparam int         CD    = 2;
    localparam logic [7:0] SEED  = 8'hA5;
    localparam int         DLY_W = $clog2(MIN + (1 << RB));

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             button = 1'b0;
    logic             led_on;
    logic             busy;
    logic             hit;
    logic             timeout;
    logic             false_start;
    logic [DLY_W-1:0] last_delay;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_lfsr;

    reaction_stimulus #(
        .TICK_DIV  (TD),
        .MIN_DELAY (MIN),
        .RAND_BITS (RB),
        .WINDOW    (WIN),
        .COOLDOWN  (CD),
        .LFSR_SEED (SEED)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .button      (button),
        .led_on      (led_on),
        .busy        (busy),
        .hit         (hit),
        .timeout     (timeout),
        .false_start (false_start),
        .last_delay  (last_delay)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reference LFSR: one step per clock from the seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_lfsr <= SEED;
        else        ref_lfsr <= lfsr_step(ref_lfsr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full round. Edge 0 is the start-sampling edge; p is the edge at which a press
    // is sampled (rel: relative to the LED rising edge). Outcome derived from the rules:
    // press up to D*TD -> false start, press in (D*TD, D*TD+WIN*TD] -> hit, else timeout.
    task automatic run_round(input int p_abs, input bit rel, input int off,
                             input bit hold, input int spur);
        int  d, l, p, hit_e, to_e, cool_e, idle_e;
        bit  fs;
        d     = MIN + int'(ref_lfsr[RB-1:0]);
        l     = d * TD;
        p     = rel ? l + off : p_abs;
        hit_e = -1;
        to_e  = -1;
        fs    = 1'b0;
        if (hold) p = 0;
        if (p >= 1 && p <= l) begin
            fs     = 1'b1;
            cool_e = p;
        end else if (p > l && p <= l + WIN * TD) begin
            hit_e  = p;
            cool_e = p;
        end else begin
            p      = 0;
            to_e   = l + WIN * TD;
            cool_e = to_e;
        end
        idle_e = cool_e + CD * TD;

        start  = 1'b1;
        button = hold;
        step();
        start  = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_delay", last_delay, d);
        chk("start_fs_clear", false_start, 0);
        chk("start_led", led_on, 0);

        for (int e = 1; e <= idle_e; e++) begin
            button = hold | (e == p);
            start  = (e == spur);
            step();
            chk("led_on", led_on, (!fs && e >= l && e < cool_e));
            chk("hit", hit, (e == hit_e));
            chk("timeout", timeout, (e == to_e));
            chk("false_start", false_start, (fs && e >= p));
            chk("busy", busy, (e < idle_e));
            chk("last_delay", last_delay, d);
        end
        start  = 1'b0;
        button = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();
        chk("rst_led", led_on, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hit", hit, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_fs", false_start, 0);
        chk("rst_delay", last_delay, 0);

        // Directed rounds
        run_round(0, 1'b1, 3, 1'b0, 0);           // hit 3 cycles after LED
        run_round(0, 1'b0, 0, 1'b0, 0);           // timeout
        run_round(2, 1'b0, 0, 1'b0, 0);           // false start 2 cycles after start
        run_round(0, 1'b0, 0, 1'b0, 30);          // clears false start; start while busy
        run_round(0, 1'b0, 0, 1'b1, 0);           // button held through start
        run_round(0, 1'b1, WIN * TD, 1'b0, 0);    // press on final LIT tick
        run_round(0, 1'b1, 0, 1'b0, 5);           // press on final ARMED tick; start while armed
        run_round(0, 1'b1, 1, 1'b0, 0);           // press on the LED's first LIT tick window

        // Randomized rounds
        for (int r = 0; r < 12; r++) begin
            int  pa;
            bit  hd;
            int  sp;
            pa = int'($urandom_range(0, 50));
            hd = ($urandom_range(0, 7) == 0);
            sp = int'($urandom_range(0, 60));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) step();
            run_round(pa, 1'b0, 0, hd, sp);
        end

        // Reset in the middle of LIT
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!led_on && n < 100) begin
            step();
            n++;
        end
        chk("reach_lit", led_on, 1);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("async_led_drop", led_on, 0);
        chk("async_busy_drop", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_led", led_on, 0);
        chk("post_rst_fs", false_start, 0);
        chk("post_rst_delay", last_delay, 0);

        // Two back-to-back rounds following the seeded LFSR sequence
        run_round(0, 1'b0, 0, 1'b0, 0);
        run_round(0, 1'b1, 2, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reaction_stimulus.md
Name: reaction_stimulus

Overview:
- Stimulus side of the reaction-time game: drives led_on and interprets the player button, one round per start pulse.
- On start, waits a pseudo-random delay, lights the LED for a bounded window, then enforces a cooldown.
- Reports three outcomes: hit (press while lit), timeout (no press) and false start (press before the LED).
- led_on and button are shared with the reaction-time measurement block, which consumes the led_on level generated here.

Parameters:
- TICK_DIV, 1000: clk cycles per time tick; must be >= 2.
- MIN_DELAY, 16: fixed part of the pre-LED delay, in ticks; must be >= 1.
- RAND_BITS, 6: width of the random delay extension, giving an extra 0..2^RAND_BITS-1 ticks; must be <= 8.
- WINDOW, 255: maximum LED-on time, in ticks; must be >= 1.
- COOLDOWN, 8: dead time after each round, in ticks; must be >= 1.
- LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a round; sampled only in IDLE
- button  in  1  player button, already synchronous to clk
- led_on  out  1  registered; high exactly while state==LIT
- busy  out  1  high in ARMED, LIT and COOL
- hit  out  1  one-cycle pulse, button rising edge during LIT
- timeout  out  1  one-cycle pulse, WINDOW expired with no press
- false_start  out  1  sticky; set on a press in ARMED, cleared when the next start is accepted
- last_delay  out  DLY_W  delay in ticks loaded for the current/last round

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, button_prev 0, LFSR = LFSR_SEED, all counters 0. Reset mid-round drops led_on immediately and asynchronously.
- Width rule: DLY_W = clog2(MIN_DELAY + 2^RAND_BITS); delay arithmetic is unsigned at DLY_W, with no overflow.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifting left.
  - Feedback = q[7]^q[5]^q[4]^q[3].
  - Advances every clk cycle, independent of state.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick asserts when the count equals TICK_DIV-1.
  - Cleared to 0 on every state transition, so all durations are exact multiples of TICK_DIV.
- Edge detect: press = button & ~button_prev. A button already held high when ARMED is entered is not a press.
- State IDLE:
  - start=1 -> ARMED.
  - Load D = MIN_DELAY + lfsr[RAND_BITS-1:0], using the LFSR value at the sampling edge; last_delay <= D; false_start <= 0.
- State ARMED:
  - Count D ticks. led_on rises exactly D*TICK_DIV cycles after the start-sampling edge -> LIT.
  - A press -> COOL with false_start <= 1; led_on never rises.
  - A press on the same cycle as the final tick counts as a false start; the press wins.
- State LIT:
  - A press -> COOL with hit pulse; led_on falls on the same edge.
  - WINDOW ticks elapse with no press -> COOL with timeout pulse. led_on is then high exactly WINDOW*TICK_DIV cycles.
  - A press on the final tick gives hit, not timeout.
- State COOL: led_on=0, busy=1; after COOLDOWN ticks -> IDLE.
- start outside IDLE is ignored; no queuing.
- hit and timeout are mutually exclusive and fire at most once per round.

Decomposition:
- Package reaction_pkg holds:
  - the state enum (IDLE, ARMED, LIT, COOL)
  - LFSR tap constants
  - the clog2-based DLY_W helper function
- One sub-module, stim_lfsr: 8-bit LFSR with seed parameter, enable tied high, parallel output.
- The FSM, prescaler, tick counters and edge detect stay in reaction_stimulus.

Test Plan:
Bench parameters for all scenarios: TICK_DIV=4, MIN_DELAY=3, RAND_BITS=2, WINDOW=5, COOLDOWN=2. The bench carries its own LFSR model.
- Reset check: reset, then idle 10 cycles -> all outputs 0; start pulse -> busy=1 next cycle, last_delay = 3 + model lfsr[1:0] (range 3..6), led_on rises exactly last_delay*4 cycles after the start edge.
- Hit: press 3 cycles after led_on rises -> hit pulses 1 cycle, led_on low on the same edge, busy low exactly 8 cycles later, timeout stays 0.
- Timeout: no press -> led_on high exactly 20 cycles, timeout pulses once, hit=0; busy then stays high 8 more cycles.
- False start: press 2 cycles after start -> false_start=1, led_on never rises, cooldown of 8 cycles; the next start clears false_start.
- Boundaries:
  - Button held high through start -> no false start.
  - Press on the final LIT tick -> hit, not timeout.
  - start pulses while busy -> ignored.
- Reset mid-round: assert rst_n=0 while LIT -> led_on drops without waiting for a clock edge; after release the block is in IDLE, and two back-to-back rounds produce the delay sequence predicted by the LFSR model from LFSR_SEED.
